fruit_spawn_controller: RTL

//  Sequences fruit (re)placement for the snake game: on each spawn request it draws a

---
 rtl/fruit_spawn_controller_if.sv | 33 +++
 rtl/fruit_spawn_controller.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fruit_spawn_controller_if.sv
// Bundles the spawn handshake, RNG feed, snake body read port and fruit outputs.
// master : requester/playfield side (drives request, rnd, head, length, body data)
// slave  : fruit_spawn_controller (drives body address, fruit state, status pulses)
interface fruit_spawn_controller_if #(
  parameter int unsigned COORD_WIDTH  = 11,
  parameter int unsigned LENGTH_WIDTH = 6
);
  logic                    spawn_req;
  logic [23:0]             rnd;
  logic [COORD_WIDTH-1:0]  head_x;
  logic [COORD_WIDTH-1:0]  head_y;
  logic [LENGTH_WIDTH-1:0] snake_len;
  logic [LENGTH_WIDTH-1:0] seg_idx;
  logic [COORD_WIDTH-1:0]  seg_x;
  logic [COORD_WIDTH-1:0]  seg_y;
  logic [COORD_WIDTH-1:0]  fruit_x;
  logic [COORD_WIDTH-1:0]  fruit_y;
  logic [1:0]              fruit_type;
  logic                    fruit_valid;
  logic                    busy;
  logic                    spawn_done;
  logic                    spawn_fail;

  modport master (
    output spawn_req, rnd, head_x, head_y, snake_len, seg_x, seg_y,
    input  seg_idx, fruit_x, fruit_y, fruit_type, fruit_valid, busy, spawn_done, spawn_fail
  );

  modport slave (
    input  spawn_req, rnd, head_x, head_y, snake_len, seg_x, seg_y,
    output seg_idx, fruit_x, fruit_y, fruit_type, fruit_valid, busy, spawn_done, spawn_fail
  );
endinterface

// File: rtl/fruit_spawn_controller.sv
// Fruit placement sequencer: draws a candidate cell from the RNG, scans the snake
// body one segment per clock, retries on collision and commits the first free cell.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      fruit_spawn_controller_if.slave (request, rnd, head, body port, fruit outputs)
module fruit_spawn_controller #(
  parameter int unsigned COORD_WIDTH    = 11,
  parameter int unsigned LENGTH_WIDTH   = 6,
  parameter int unsigned DISPLAY_WIDTH  = 136,
  parameter int unsigned DISPLAY_HEIGHT = 76,
  parameter int unsigned BLOCK_SIZE     = 10,
  parameter int unsigned MAX_TRIES      = 10,
  parameter int unsigned INIT_X         = 100,
  parameter int unsigned INIT_Y         = 100
) (
  input  logic clk,
  input  logic reset_n,
  fruit_spawn_controller_if.slave bus
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam int unsigned CW = COORD_WIDTH;
  localparam int unsigned LW = LENGTH_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_SCAN,
    S_COMMIT,
    S_FAIL
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tries;
  logic [LW-1:0]   r_len_l;
  logic [LW-1:0]   r_seg_idx;
  logic [CW-1:0]   r_cand_x;
  logic [CW-1:0]   r_cand_y;
  logic [1:0]      r_cand_t;
  logic [CW-1:0]   r_fruit_x;
  logic [CW-1:0]   r_fruit_y;
  logic [1:0]      r_fruit_t;
  logic            r_fruit_valid;
  logic            r_busy;
  logic            r_done;
  logic            r_fail;

  // Candidate cell from the RNG fields; products stay <= 1350 so CW bits suffice.
  logic [11:0]     w_cell_x;
  logic [11:0]     w_cell_y;
  logic [CW-1:0]   w_draw_x;
  logic [CW-1:0]   w_draw_y;
  logic [1:0]      w_draw_t;
  logic            w_hit;
  logic            w_last;
  logic [TW-1:0]   w_tries_nxt;

  assign w_cell_x    = bus.rnd[11:0]  % 12'(DISPLAY_WIDTH);
  assign w_cell_y    = bus.rnd[23:12] % 12'(DISPLAY_HEIGHT);
  assign w_draw_x    = CW'(w_cell_x * 12'(BLOCK_SIZE));
  assign w_draw_y    = CW'(w_cell_y * 12'(BLOCK_SIZE));
  assign w_draw_t    = (bus.rnd[2:1] == 2'b00) ? 2'b01 : bus.rnd[2:1];

  // The head is not part of the body memory, so it is checked alongside segment 0.
  assign w_hit       = ((bus.seg_x == r_cand_x) && (bus.seg_y == r_cand_y)) ||
                       ((r_seg_idx == '0) && (bus.head_x == r_cand_x) && (bus.head_y == r_cand_y));
  assign w_last      = (r_seg_idx == (r_len_l - LW'(1)));
  assign w_tries_nxt = r_tries + TW'(1);

  // Search sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_tries       <= '0;
      r_len_l       <= LW'(1);
      r_seg_idx     <= '0;
      r_cand_x      <= '0;
      r_cand_y      <= '0;
      r_cand_t      <= 2'b01;
      r_fruit_x     <= CW'(INIT_X);
      r_fruit_y     <= CW'(INIT_Y);
      r_fruit_t     <= 2'b01;
      r_fruit_valid <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.spawn_req) begin
            r_fruit_valid <= 1'b0;
            r_busy        <= 1'b1;
            r_tries       <= '0;
            r_len_l       <= (bus.snake_len == '0) ? LW'(1) : bus.snake_len;
            r_state       <= S_DRAW;
          end
        end
        S_DRAW: begin
          r_cand_x  <= w_draw_x;
          r_cand_y  <= w_draw_y;
          r_cand_t  <= w_draw_t;
          r_seg_idx <= '0;
          r_state   <= S_SCAN;
        end
        S_SCAN: begin
          if (w_hit) begin
            r_tries <= w_tries_nxt;
            r_state <= (w_tries_nxt == TW'(MAX_TRIES)) ? S_FAIL : S_DRAW;
          end else if (w_last) begin
            r_state <= S_COMMIT;
          end else begin
            r_seg_idx <= r_seg_idx + LW'(1);
          end
        end
        S_COMMIT: begin
          r_fruit_x     <= r_cand_x;
          r_fruit_y     <= r_cand_y;
          r_fruit_t     <= r_cand_t;
          r_fruit_valid <= 1'b1;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        S_FAIL: begin
          r_fail  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.seg_idx     = r_seg_idx;
  assign bus.fruit_x     = r_fruit_x;
  assign bus.fruit_y     = r_fruit_y;
  assign bus.fruit_type  = r_fruit_t;
  assign bus.fruit_valid = r_fruit_valid;
  assign bus.busy        = r_busy;
  assign bus.spawn_done  = r_done;
  assign bus.spawn_fail  = r_fail;

endmodule
